uart_loader: RTL and testbench
==============================

// Module: uart_loader
// PURPOSE
//   Program loader directly downstream of the UART receiver. It consumes received bytes
//   (RX_data qualified by byte_done) and parses a framed packet: sync, start address,
//   word count, payload, checksum. It writes each assembled little-endian 32-bit word into
//   instruction/data memory and holds the core in reset while a load is in progress.
// PARAMETERS
//   SYNC_BYTE      8'hA5   first byte of every packet; all other bytes in IDLE are ignored
//   MAX_WORDS      4096    largest accepted word count; a larger count is an error
//   TIMEOUT_CYCLES 57000   idle cycles allowed between bytes inside a packet (1 ms @ 57 MHz)
// PORTS
//   clk        in   1   system clock (57 MHz)
//   rst        in   1   synchronous, active-high reset
//   byte_done  in   1   UART byte-complete flag; may stay high for more than one cycle
//   RX_data    in   8   UART received byte, valid while byte_done is high
//   mem_we     out  1   one-cycle memory write strobe
//   mem_addr   out  32  byte address of the write, always word aligned
//   mem_wdata  out  32  write data
//   load_active out 1   high from sync-byte accept to packet end; drives core reset
//   load_done  out  1   one-cycle pulse when a packet completes with a good checksum
//   load_err   out  1   sticky error flag; cleared when the next sync byte is accepted
// BEHAVIOUR
//   - Reset: all outputs 0, state IDLE, internal counters and accumulators 0.
//   - Byte strobe: byte_v = byte_done & ~byte_done_q, where byte_done_q is a registered copy.
//     Exactly one byte is consumed per rising edge of byte_done. RX_data is sampled on the
//     byte_v cycle.
//   - States and transitions on byte_v:
//     IDLE: byte == SYNC_BYTE -> ADDR; load_active<=1, load_err<=0, byte_cnt<=0.
//           Any other byte is dropped.
//     ADDR: collect 4 bytes, LSB first, into addr. After the 4th byte: if addr[1:0]!=0 -> ERR,
//           else -> LEN.
//     LEN:  collect 4 bytes, LSB first, into len. After the 4th byte:
//           len > MAX_WORDS -> ERR; len == 0 -> CSUM; otherwise -> DATA.
//     DATA: shift bytes into the word register, LSB first. On the 4th byte, pulse mem_we on the
//           NEXT cycle with mem_addr = addr + 4*word_idx, then increment word_idx.
//           After word len-1 -> CSUM.
//     CSUM: 1 byte. If it equals the XOR of all payload bytes (0 when len==0) -> DONE, else -> ERR.
//     DONE: 1 cycle. load_done=1, load_active<=0 -> IDLE.
//     ERR:  1 cycle. load_err<=1, load_active<=0 -> IDLE. Writes already issued are not undone.
//   - Latency: mem_we is asserted exactly 1 cycle after the byte_v of the 4th byte of each word.
//     load_done is asserted 1 cycle after the checksum byte_v.
//   - mem_addr / mem_wdata hold their values between strobes. Address arithmetic is 32-bit modulo.
//   - Timeout: the counter clears on every byte_v and counts in every non-IDLE state.
//     Reaching TIMEOUT_CYCLES -> ERR. A byte_v arriving in the same cycle as the timeout wins
//     and clears the counter.
//   - The checksum XOR accumulator clears on sync accept.
//   - A sync-valued byte inside ADDR/LEN/DATA/CSUM is treated as data and does not restart
//     the packet.
//   - rst asserted mid-packet: immediate return to IDLE; mem_we, load_active and load_err go
//     to 0 on the next edge.
// TESTING
//   1. Packet A5, 00 01 00 00, 02 00 00 00, 11 22 33 44, 55 66 77 88, csum 88 ->
//      mem_we at 0x100 = 0x44332211 and at 0x104 = 0x88776655; load_done pulses once;
//      load_err stays 0.
//   2. Same packet with csum 00 -> both writes occur, load_err=1, no load_done,
//      load_active falls.
//   3. Bytes 3C, 00 then A5, addr 0x00000002 -> first two bytes ignored; ERR on misalignment;
//      no mem_we.
//   4. byte_done held high 500 cycles per byte -> each byte consumed once; word count and
//      address are correct.
//   5. Stop sending after 2 payload bytes -> load_err=1 after 57000 cycles; next A5 clears
//      load_err and raises load_active.
//   6. len=0 with csum 00 -> load_done and no mem_we. Also: rst pulsed mid-DATA ->
//      load_active=0 next cycle and no further writes.

Source files
------------

// File: rtl/uart_loader.sv
// rtl/uart_loader.sv - framed UART packet parser that writes 32-bit words to memory
// Packet: sync, 4-byte address, 4-byte word count, payload, XOR checksum; all fields LSB first.
module uart_loader #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         MAX_WORDS      = 4096,
    parameter int         TIMEOUT_CYCLES = 57000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        byte_done,
    input  logic [7:0]  RX_data,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        load_active,
    output logic        load_done,
    output logic        load_err
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_LEN, S_DATA, S_CSUM, S_DONE, S_ERR
    } state_t;

    state_t      state;
    logic        byte_done_q;
    logic        byte_v;
    logic [1:0]  byte_cnt;
    logic [31:0] addr;
    logic [31:0] len;
    logic [31:0] word;
    logic [12:0] word_idx;
    logic [7:0]  csum;
    logic [TW-1:0] tcnt;
    logic        timeout;
    logic [31:0] addr_next;
    logic [31:0] len_next;
    logic [31:0] word_next;

    assign byte_v    = byte_done & ~byte_done_q;
    assign timeout   = (tcnt == TW'(TIMEOUT_CYCLES - 1));
    assign addr_next = {RX_data, addr[31:8]};
    assign len_next  = {RX_data, len[31:8]};
    assign word_next = {RX_data, word[31:8]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            byte_done_q <= 1'b0;
            byte_cnt    <= 2'd0;
            addr        <= 32'd0;
            len         <= 32'd0;
            word        <= 32'd0;
            word_idx    <= 13'd0;
            csum        <= 8'd0;
            tcnt        <= '0;
            mem_we      <= 1'b0;
            mem_addr    <= 32'd0;
            mem_wdata   <= 32'd0;
            load_active <= 1'b0;
            load_done   <= 1'b0;
            load_err    <= 1'b0;
        end else begin
            byte_done_q <= byte_done;
            mem_we      <= 1'b0;
            load_done   <= 1'b0;
            // Inter-byte watchdog: only meaningful while a packet is open.
            if (byte_v || state == S_IDLE)
                tcnt <= '0;
            else
                tcnt <= tcnt + 1'b1;

            case (state)
                S_IDLE: begin
                    if (byte_v && RX_data == SYNC_BYTE) begin
                        state       <= S_ADDR;
                        load_active <= 1'b1;
                        load_err    <= 1'b0;
                        byte_cnt    <= 2'd0;
                        csum        <= 8'd0;
                        word_idx    <= 13'd0;
                    end
                end
                S_ADDR: begin
                    if (byte_v) begin
                        addr     <= addr_next;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3)
                            state <= (addr_next[1:0] != 2'b00) ? S_ERR : S_LEN;
                    end else if (timeout) begin
                        state <= S_ERR;
                    end
                end
                S_LEN: begin
                    if (byte_v) begin
                        len      <= len_next;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            if (len_next > 32'(MAX_WORDS))
                                state <= S_ERR;
                            else if (len_next == 32'd0)
                                state <= S_CSUM;
                            else
                                state <= S_DATA;
                        end
                    end else if (timeout) begin
                        state <= S_ERR;
                    end
                end
                S_DATA: begin
                    if (byte_v) begin
                        word     <= word_next;
                        csum     <= csum ^ RX_data;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            mem_we    <= 1'b1;
                            mem_addr  <= addr + {17'd0, word_idx, 2'b00};
                            mem_wdata <= word_next;
                            word_idx  <= word_idx + 13'd1;
                            if ({19'd0, word_idx} == len - 32'd1)
                                state <= S_CSUM;
                        end
                    end else if (timeout) begin
                        state <= S_ERR;
                    end
                end
                S_CSUM: begin
                    if (byte_v) begin
                        if (RX_data == csum) begin
                            state     <= S_DONE;
                            load_done <= 1'b1;
                        end else begin
                            state <= S_ERR;
                        end
                    end else if (timeout) begin
                        state <= S_ERR;
                    end
                end
                S_DONE: begin
                    load_active <= 1'b0;
                    state       <= S_IDLE;
                end
                S_ERR: begin
                    load_err    <= 1'b1;
                    load_active <= 1'b0;
                    state       <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_loader.sv
// tb/tb_uart_loader.sv - scoreboard bench for uart_loader with a packet-level reference model
module tb_uart_loader;
    logic        clk = 1'b0;
    logic        rst;
    logic        byte_done;
    logic [7:0]  rx_data;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        load_active;
    logic        load_done;
    logic        load_err;

    uart_loader dut (
        .clk(clk), .rst(rst), .byte_done(byte_done), .RX_data(rx_data),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .load_active(load_active), .load_done(load_done), .load_err(load_err)
    );

    initial forever #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    longint      cyc   = 0;
    longint      last_byte_cyc = 0;
    longint      err_cyc = 0;
    logic        err_q = 1'b0;
    logic [63:0] exp_wq[$];
    bit          exp_oq[$];
    logic [7:0]  pkt[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input logic [63:0] act);
        total++;
        bad++;
        $display("FAIL %s: got %h expected nothing", name, act);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a write or a packet outcome.
    initial forever begin
        @(negedge clk);
        cyc++;
        if (rst) begin
            err_q = 1'b0;
        end else begin
            if (mem_we) begin
                if (exp_wq.size() == 0) fail_now("unexpected_write", {mem_addr, mem_wdata});
                else check("write", {mem_addr, mem_wdata}, exp_wq.pop_front());
            end
            if (load_done || (load_err && !err_q)) begin
                if (load_err) err_cyc = cyc;
                if (exp_oq.size() == 0) fail_now("unexpected_outcome", {62'd0, load_err, load_done});
                else check("outcome_done", 64'(load_done), 64'(exp_oq.pop_front()));
            end
            err_q = load_err;
        end
    end

    // Reference model: parse the first n bytes of pkt as the packet rules describe.
    task automatic model(input int n, input bit with_out);
        logic [31:0] a;
        logic [31:0] l;
        logic [7:0]  x;
        int          p;
        if (n < 5) begin
            if (with_out) exp_oq.push_back(1'b0);
            return;
        end
        a = {pkt[4], pkt[3], pkt[2], pkt[1]};
        if (a[1:0] != 2'b00 || n < 9) begin
            if (with_out) exp_oq.push_back(1'b0);
            return;
        end
        l = {pkt[8], pkt[7], pkt[6], pkt[5]};
        if (l > 32'd4096) begin
            if (with_out) exp_oq.push_back(1'b0);
            return;
        end
        x = 8'd0;
        for (int k = 0; k < int'(l); k++) begin
            p = 9 + 4 * k;
            if (p + 4 > n) begin
                if (with_out) exp_oq.push_back(1'b0);
                return;
            end
            exp_wq.push_back({a + 32'(4 * k), pkt[p+3], pkt[p+2], pkt[p+1], pkt[p]});
            x = x ^ pkt[p] ^ pkt[p+1] ^ pkt[p+2] ^ pkt[p+3];
        end
        p = 9 + 4 * int'(l);
        if (with_out) exp_oq.push_back((p < n) && (pkt[p] == x));
    endtask

    task automatic build(input logic [31:0] a, input logic [31:0] l, input int nwords, input bit bad_csum);
        logic [7:0] x;
        logic [7:0] b;
        pkt = {};
        pkt.push_back(8'hA5);
        for (int i = 0; i < 4; i++) pkt.push_back(a[8*i +: 8]);
        for (int i = 0; i < 4; i++) pkt.push_back(l[8*i +: 8]);
        x = 8'd0;
        for (int i = 0; i < 4 * nwords; i++) begin
            b = 8'($urandom);
            pkt.push_back(b);
            x = x ^ b;
        end
        if (bad_csum) x = x ^ 8'($urandom_range(1, 255));
        pkt.push_back(x);
    endtask

    task automatic send_byte(input logic [7:0] b, input int hold, input int gap);
        @(posedge clk);
        #1;
        rx_data       = b;
        byte_done     = 1'b1;
        last_byte_cyc = cyc;
        repeat (hold) @(posedge clk);
        #1;
        byte_done = 1'b0;
        rx_data   = 8'($urandom);
        repeat (gap) @(posedge clk);
    endtask

    task automatic send_packet(input int n, input int hold);
        for (int i = 0; i < n; i++) begin
            send_byte(pkt[i], hold, 2);
            if (i == 0) begin
                #1;
                check("active_after_sync", 64'(load_active), 64'd1);
                check("err_clear_after_sync", 64'(load_err), 64'd0);
            end
        end
    endtask

    task automatic wait_done();
        for (int i = 0; i < 60000; i++) begin
            if (exp_wq.size() == 0 && exp_oq.size() == 0) break;
            @(posedge clk);
        end
        if (exp_wq.size() != 0 || exp_oq.size() != 0) begin
            fail_now("wait_timeout", 64'(exp_wq.size() + exp_oq.size()));
            exp_wq = {};
            exp_oq = {};
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        int          kind;
        int          nw;
        logic [31:0] a;
        logic [7:0]  g;
        rst       = 1'b1;
        byte_done = 1'b0;
        rx_data   = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mem_we", 64'(mem_we), 64'd0);
        check("rst_active", 64'(load_active), 64'd0);
        check("rst_err", 64'(load_err), 64'd0);
        check("rst_done", 64'(load_done), 64'd0);
        check("rst_addr", 64'(mem_addr), 64'd0);
        check("rst_wdata", 64'(mem_wdata), 64'd0);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // Two-word packet with good checksum, then the same with a bad one.
        pkt = '{8'hA5, 8'h00, 8'h01, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00,
                8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h88};
        model(pkt.size(), 1'b1);
        send_packet(pkt.size(), 1);
        wait_done();
        check("t1_active", 64'(load_active), 64'd0);
        check("t1_err", 64'(load_err), 64'd0);

        pkt[pkt.size() - 1] = 8'h00;
        model(pkt.size(), 1'b1);
        send_packet(pkt.size(), 1);
        wait_done();
        check("t2_active", 64'(load_active), 64'd0);
        check("t2_err", 64'(load_err), 64'd1);

        // Idle garbage then a misaligned start address.
        send_byte(8'h3C, 1, 2);
        send_byte(8'h00, 1, 2);
        #1;
        check("garbage_ignored", 64'(load_active), 64'd0);
        pkt = '{8'hA5, 8'h02, 8'h00, 8'h00, 8'h00};
        model(5, 1'b1);
        send_packet(5, 1);
        wait_done();
        check("t3_err", 64'(load_err), 64'd1);

        // byte_done held high for many cycles per byte.
        build(32'h0000_2000, 32'd3, 3, 1'b0);
        model(pkt.size(), 1'b1);
        send_packet(pkt.size(), 500);
        wait_done();

        // Stall after two payload bytes, then recover with an empty packet.
        build(32'h0000_0040, 32'd2, 2, 1'b0);
        model(11, 1'b1);
        send_packet(11, 1);
        wait_done();
        check("timeout_err", 64'(load_err), 64'd1);
        check("timeout_window", 64'((err_cyc - last_byte_cyc) >= 56995 && (err_cyc - last_byte_cyc) <= 57010), 64'd1);
        build(32'h0000_0080, 32'd0, 0, 1'b0);
        model(pkt.size(), 1'b1);
        send_packet(pkt.size(), 1);
        wait_done();
        check("len0_err", 64'(load_err), 64'd0);

        // Reset in the middle of the payload after one completed word.
        build(32'h0000_0300, 32'd3, 3, 1'b0);
        model(15, 1'b0);
        send_packet(15, 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid_active", 64'(load_active), 64'd0);
        check("rst_mid_we", 64'(mem_we), 64'd0);
        rst = 1'b0;
        repeat (100) @(posedge clk);
        check("rst_mid_pending", 64'(exp_wq.size()), 64'd0);
        exp_wq = {};

        // Randomized packets: good, corrupt checksum, misaligned, oversize, wrapping address.
        for (int it = 0; it < 12; it++) begin
            kind = $urandom_range(0, 9);
            nw   = $urandom_range(0, 5);
            a    = $urandom & 32'hFFFF_FFFC;
            if (kind == 9) a = 32'hFFFF_FFF8;
            if ($urandom_range(0, 1) == 1) begin
                g = 8'($urandom);
                if (g == 8'hA5) g = 8'h5A;
                send_byte(g, 1, 2);
            end
            if (kind == 0) begin
                build(a | 32'($urandom_range(1, 3)), 32'(nw), 0, 1'b0);
                model(5, 1'b1);
                send_packet(5, 1);
            end else if (kind == 1) begin
                build(a, 32'd4097 + 32'($urandom_range(0, 1000)), 0, 1'b0);
                model(9, 1'b1);
                send_packet(9, 1);
            end else begin
                build(a, 32'(nw), nw, kind == 2);
                model(pkt.size(), 1'b1);
                send_packet(pkt.size(), $urandom_range(1, 3));
            end
            wait_done();
            check("rand_idle", 64'(load_active), 64'd0);
        end

        check("final_wq_empty", 64'(exp_wq.size()), 64'd0);
        check("final_oq_empty", 64'(exp_oq.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
